// File: rtl/pwm_gen_multi_if.sv
// Purpose : control/config bundle between the peripheral register file and pwm_gen_multi.
// Latency : n/a (wires only).
// Backpressure: none; cfg_wr is a one-cycle strobe that is always accepted.
// Signals:
//   pwm_en        global enable (0 freezes counter and outputs)
//   cfg_wr        strobe capturing every cfg_* field into the pending set
//   cfg_period    counter terminal value
//   cfg_prescale  counter advances every cfg_prescale+1 clocks
//   cfg_functions per channel {unaligned, right_align}, ch i at [2i+1:2i]
//   cfg_compare1  per channel threshold 1, ch i at [WIDTH*i +: WIDTH]
//   cfg_compare2  per channel threshold 2 (unaligned mode)
//   cfg_pending   pending set written but not yet applied
//   count_val     current period counter
//   pwm_out       registered PWM outputs
interface pwm_gen_multi_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4,
  parameter int PSC_W  = 8
);
  logic                    pwm_en;
  logic                    cfg_wr;
  logic [WIDTH-1:0]        cfg_period;
  logic [PSC_W-1:0]        cfg_prescale;
  logic [2*NUM_CH-1:0]     cfg_functions;
  logic [WIDTH*NUM_CH-1:0] cfg_compare1;
  logic [WIDTH*NUM_CH-1:0] cfg_compare2;
  logic                    cfg_pending;
  logic [WIDTH-1:0]        count_val;
  logic [NUM_CH-1:0]       pwm_out;

  // Register-file side.
  modport master (
    output pwm_en, cfg_wr, cfg_period, cfg_prescale, cfg_functions,
           cfg_compare1, cfg_compare2,
    input  cfg_pending, count_val, pwm_out
  );

  // PWM generator side.
  modport slave (
    input  pwm_en, cfg_wr, cfg_period, cfg_prescale, cfg_functions,
           cfg_compare1, cfg_compare2,
    output cfg_pending, count_val, pwm_out
  );
endinterface

// File: rtl/pwm_gen_multi.sv
// Purpose : multi-channel PWM generator, one shared prescaled counter, double-buffered config.
// Latency : pwm_out is registered, 1 clock behind count_val; new config applies at the next wrap.
// Backpressure: none; cfg_wr always accepted, a later write overwrites a not-yet-applied pending set.
// Ports:
//   clk, rst_n   peripheral clock, asynchronous active-low reset
//   bus (slave)  pwm_en, cfg_wr, cfg_* inputs; cfg_pending, count_val, pwm_out outputs
//   irq, irq_clr sticky wrap interrupt and its clear (only when PWM_GEN_IRQ_EN is defined)
// Build option: define PWM_GEN_IRQ_EN to add the wrap interrupt.
module pwm_gen_multi #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4,
  parameter int PSC_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef PWM_GEN_IRQ_EN
  input  logic irq_clr,
  output logic irq,
`endif
  pwm_gen_multi_if.slave bus
);

  // Active set drives the counter/compare logic; pending set holds the latest write.
  logic [WIDTH-1:0]        act_period,  pend_period;
  logic [PSC_W-1:0]        act_psc,     pend_psc;
  logic [2*NUM_CH-1:0]     act_func,    pend_func;
  logic [WIDTH*NUM_CH-1:0] act_cmp1,    pend_cmp1;
  logic [WIDTH*NUM_CH-1:0] act_cmp2,    pend_cmp2;
  logic                    pend_vld;

  logic [PSC_W-1:0]  psc_q;
  logic [WIDTH-1:0]  cnt_q;
  logic [NUM_CH-1:0] out_q;
  logic [NUM_CH-1:0] out_nxt;
  logic              tick;
  logic              wrap;
  logic              apply;

  assign tick  = bus.pwm_en && (psc_q == act_psc);
  assign wrap  = tick && (cnt_q == act_period);
  // Apply at a period boundary, or straight away while stopped so a
  // disabled block never sits on stale settings.
  assign apply = pend_vld && (wrap || !bus.pwm_en);

  function automatic logic chan_out(input logic [1:0]       fn,
                                    input logic [WIDTH-1:0] cnt,
                                    input logic [WIDTH-1:0] c1,
                                    input logic [WIDTH-1:0] c2);
    if (fn[1])      chan_out = (c1 <= cnt) && (cnt < c2);
    else if (fn[0]) chan_out = (cnt >= c1);
    else            chan_out = (cnt < c1);
  endfunction

  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      out_nxt[i] = chan_out(act_func[2*i +: 2], cnt_q,
                            act_cmp1[WIDTH*i +: WIDTH],
                            act_cmp2[WIDTH*i +: WIDTH]);
    end
  end

  // Prescaler and period counter; both hold while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
      cnt_q <= '0;
    end else if (bus.pwm_en) begin
      if (tick) begin
        psc_q <= '0;
        cnt_q <= (cnt_q == act_period) ? '0 : cnt_q + WIDTH'(1);
      end else begin
        psc_q <= psc_q + PSC_W'(1);
      end
    end
  end

  // Double-buffered configuration. A write coinciding with an apply lands in
  // pending after the old pending contents have moved to active, so
  // pend_vld stays set for the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_period <= '0;
      pend_psc    <= '0;
      pend_func   <= '0;
      pend_cmp1   <= '0;
      pend_cmp2   <= '0;
      pend_vld    <= 1'b0;
      act_period  <= '0;
      act_psc     <= '0;
      act_func    <= '0;
      act_cmp1    <= '0;
      act_cmp2    <= '0;
    end else begin
      if (apply) begin
        act_period <= pend_period;
        act_psc    <= pend_psc;
        act_func   <= pend_func;
        act_cmp1   <= pend_cmp1;
        act_cmp2   <= pend_cmp2;
      end
      if (bus.cfg_wr) begin
        pend_period <= bus.cfg_period;
        pend_psc    <= bus.cfg_prescale;
        pend_func   <= bus.cfg_functions;
        pend_cmp1   <= bus.cfg_compare1;
        pend_cmp2   <= bus.cfg_compare2;
        pend_vld    <= 1'b1;
      end else if (apply) begin
        pend_vld    <= 1'b0;
      end
    end
  end

  // Outputs compare the current count against the active set, so they lag count_val by a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          out_q <= '0;
    else if (bus.pwm_en) out_q <= out_nxt;
  end

`ifdef PWM_GEN_IRQ_EN
  logic irq_flag;

  // Sticky wrap flag; a wrap in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       irq_flag <= 1'b0;
    else if (wrap)    irq_flag <= 1'b1;
    else if (irq_clr) irq_flag <= 1'b0;
  end

  assign irq = irq_flag;
`else
  // No interrupt flag in this build; wraps only drive the config apply.
`endif

  assign bus.cfg_pending = pend_vld;
  assign bus.count_val   = cnt_q;
  assign bus.pwm_out     = out_q;

endmodule

// File: doc/pwm_gen_multi.md
Name: pwm_gen_multi

Overview:
Multi-channel PWM generator. It has one internal prescaled period counter shared by NUM_CH channels, and each channel has its own mode and compare thresholds. Configuration is double-buffered: register writes land in a pending set and take effect atomically at the period boundary, so no glitched periods occur. It sits behind the peripheral register file and drives the top-level PWM pins.

Parameters:
- WIDTH, 16, counter/period/compare width in bits.
- NUM_CH, 4, number of PWM channels (1..16).
- PSC_W, 8, prescaler register width.

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  asynchronous active-low reset
- pwm_en  in  1  global enable; 0 freezes counter and outputs
- cfg_wr  in  1  single-cycle strobe; captures all cfg_* inputs into the pending set
- cfg_period  in  WIDTH  counter terminal value
- cfg_prescale  in  PSC_W  counter advances every cfg_prescale+1 clocks
- cfg_functions  in  2*NUM_CH  per channel {unaligned, right_align}; ch i at [2i+1:2i]
- cfg_compare1  in  WIDTH*NUM_CH  per-channel threshold 1; ch i at [WIDTH*i +: WIDTH]
- cfg_compare2  in  WIDTH*NUM_CH  per-channel threshold 2 (unaligned mode only)
- cfg_pending  out  1  pending set not yet applied
- count_val  out  WIDTH  current counter value
- pwm_out  out  NUM_CH  PWM outputs, registered

Behaviour:
Reset values:
- count_val=0, prescaler=0, pwm_out=0, cfg_pending=0.
- Active and pending registers are all 0, so period=0, prescale=0, all channels left-aligned with compare1=0 (outputs low).

Prescaler and tick:
- The prescaler counts 0..act_prescale while pwm_en=1.
- tick=1 in the cycle the prescaler equals act_prescale; the prescaler then wraps to 0.
- act_prescale=0 gives tick every clock.

Counter:
- On tick: if count_val==act_period, count_val<=0 (wrap); otherwise count_val<=count_val+1.
- act_period=0 gives count_val held at 0 with a wrap on every tick.
- Arithmetic is unsigned WIDTH-bit.

Enable:
- pwm_en=0 holds prescaler, count_val and pwm_out at their current values. No reset occurs.
- Re-enabling resumes from the held state.

Double buffering:
- cfg_wr copies all cfg_* into pending and sets cfg_pending=1.
- The pending set is copied into the active set, and cfg_pending clears, in the same cycle as either:
  - a wrap (tick with count_val==act_period), or
  - any cycle with pwm_en=0 and cfg_pending=1.
- cfg_wr in the same cycle as an apply: the apply uses the old pending contents, the new write is captured, and cfg_pending stays 1.
- Active registers change only at an apply.

Output function (count_val is the current value, evaluated every cycle with pwm_en=1; pwm_out registered, so 1-clock latency from count_val):
- Left aligned (functions=00): out = count_val < compare1.
- Right aligned (01): out = count_val >= compare1.
- Unaligned (1x): out = (compare1 <= count_val) && (count_val < compare2).

Boundary cases:
- compare1=0 left-aligned gives constant 0.
- compare1 > act_period left-aligned gives constant 1; right-aligned gives constant 0.
- Unaligned with compare1 >= compare2 gives constant 0.
- All comparisons use active-set values.
- rst_n asserted mid-period clears everything immediately, including pending data.

Optional Feature:
Macro PWM_GEN_IRQ_EN.
- Defined: adds ports irq (out, 1) and irq_clr (in, 1).
  - An internal sticky flag sets on every wrap; irq mirrors the flag.
  - irq_clr=1 clears the flag; a wrap in the same cycle wins (flag stays 1).
  - Reset value of irq is 0.
- Undefined: the ports and the flag are absent; all other behaviour is identical.

Test Plan:
1. Reset, then cfg_wr period=9, prescale=0, ch0 left compare1=3, pwm_en=1 -> applies immediately (was disabled); count_val cycles 0..9; pwm_out[0] high for 3 of every 10 clocks, lagging count_val by 1 clock.
2. prescale=2, period=4 -> count_val increments every 3 clocks; period lasts 15 clocks; duty pattern scales by 3.
3. Running with ch1 right compare1=6 (period 9); cfg_wr compare1=2 at count_val=4 -> cfg_pending=1; the old duty holds until the wrap; from the next period the output is high 8/10; cfg_pending clears in the wrap cycle.
4. ch2 unaligned compare1=2, compare2=7, period 9 -> high for count_val 2..6; then compare1=7, compare2=2 -> constant 0; left compare1=0 -> 0; left compare1=12 -> 1.
5. pwm_en dropped at count_val=5 for 20 clocks -> count_val and pwm_out frozen; re-enable -> continues at 6. rst_n pulsed mid-period -> all outputs 0 and cfg_pending 0 asynchronously.
6. (PWM_GEN_IRQ_EN) period=3 -> irq rises on the first wrap; irq_clr coincident with a wrap -> irq stays 1; irq_clr alone -> irq 0 the next cycle.
